interpolator_10x: RTL and testbench

INTERPOLATOR_10X -- requirements
Module: interpolator_10x

---
 rtl/interpolator_10x.sv | 114 +++++++++++
 tb/tb_interpolator_10x.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/interpolator_10x.sv
// Ten-phase linear interpolator: per frame, produces y_k = round((x0*(10-k) + x1*k) / 10), k=0..9,
// and publishes all ten values together with a one-clock end_stage pulse.
module interpolator_10x (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       clk_en_10x,
  input  logic [7:0] sample_x0,
  input  logic [7:0] sample_x1,
  output logic       end_stage,
  output logic [7:0] sample_y0,
  output logic [7:0] sample_y1,
  output logic [7:0] sample_y2,
  output logic [7:0] sample_y3,
  output logic [7:0] sample_y4,
  output logic [7:0] sample_y5,
  output logic [7:0] sample_y6,
  output logic [7:0] sample_y7,
  output logic [7:0] sample_y8,
  output logic [7:0] sample_y9
);

  localparam int unsigned DW = 8;
  localparam int unsigned NS = 10;
  localparam int unsigned KW = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned PW = 25;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [DW-1:0]   x0_q, x0_d;
  logic [DW-1:0]   x1_q, x1_d;
  logic [DW-1:0]   w_q [NS];
  logic [DW-1:0]   w_d [NS];
  logic [DW-1:0]   y_q [NS];
  logic [DW-1:0]   y_d [NS];
  logic            end_stage_q, end_stage_d;

  logic [KW-1:0]   k_nx;
  logic [AW-1:0]   num;
  logic [DW-1:0]   wk;

  // Weighted sum for the next step, then /10 as *6554>>16 (exact for num < 16384).
  always_comb begin
    k_nx = k_q + KW'(1);
    num  = AW'(AW'(x0_q) * AW'(KW'(10) - k_nx)) + AW'(AW'(x1_q) * AW'(k_nx)) + AW'(5);
    wk   = DW'((PW'(num) * PW'(6554)) >> 16);
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    w_d         = w_q;
    y_d         = y_q;
    end_stage_d = 1'b0;
    if (clk_en) begin
      // A new frame always wins, including over a simultaneous step or an unfinished frame.
      x0_d    = sample_x0;
      x1_d    = sample_x1;
      k_d     = '0;
      w_d[0]  = sample_x0;
      state_d = BUSY;
    end else if (state_q == BUSY && clk_en_10x) begin
      w_d[k_nx] = wk;
      k_d       = k_nx;
      if (k_nx == KW'(9)) begin
        for (int i = 0; i < 9; i++) y_d[i] = w_q[i];
        y_d[9]      = wk;
        end_stage_d = 1'b1;
        k_d         = '0;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      end_stage_q <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        w_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      end_stage_q <= end_stage_d;
      w_q         <= w_d;
      y_q         <= y_d;
    end
  end

  assign end_stage = end_stage_q;
  assign sample_y0 = y_q[0];
  assign sample_y1 = y_q[1];
  assign sample_y2 = y_q[2];
  assign sample_y3 = y_q[3];
  assign sample_y4 = y_q[4];
  assign sample_y5 = y_q[5];
  assign sample_y6 = y_q[6];
  assign sample_y7 = y_q[7];
  assign sample_y8 = y_q[8];
  assign sample_y9 = y_q[9];

endmodule

// File: tb/tb_interpolator_10x.sv
// Bench for interpolator_10x: directed and random frames checked against an arithmetic reference.
module tb_interpolator_10x;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       clk_en_10x;
  logic [7:0] sample_x0;
  logic [7:0] sample_x1;
  logic       end_stage;
  logic [7:0] sample_y0, sample_y1, sample_y2, sample_y3, sample_y4;
  logic [7:0] sample_y5, sample_y6, sample_y7, sample_y8, sample_y9;
  logic [7:0] ys [10];

  int total = 0;
  int bad   = 0;

  int m_x0, m_x1, m_k;
  bit m_busy;
  int exp_y [10];

  always #10 clk = ~clk;

  interpolator_10x dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .clk_en_10x (clk_en_10x),
    .sample_x0  (sample_x0),
    .sample_x1  (sample_x1),
    .end_stage  (end_stage),
    .sample_y0  (sample_y0),
    .sample_y1  (sample_y1),
    .sample_y2  (sample_y2),
    .sample_y3  (sample_y3),
    .sample_y4  (sample_y4),
    .sample_y5  (sample_y5),
    .sample_y6  (sample_y6),
    .sample_y7  (sample_y7),
    .sample_y8  (sample_y8),
    .sample_y9  (sample_y9)
  );

  assign ys[0] = sample_y0;
  assign ys[1] = sample_y1;
  assign ys[2] = sample_y2;
  assign ys[3] = sample_y3;
  assign ys[4] = sample_y4;
  assign ys[5] = sample_y5;
  assign ys[6] = sample_y6;
  assign ys[7] = sample_y7;
  assign ys[8] = sample_y8;
  assign ys[9] = sample_y9;

  function automatic int interp(input int a, input int b, input int k);
    return (a * (10 - k) + b * k + 5) / 10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s_y%0d", tag, i), 32'(ys[i]), 32'(exp_y[i]));
  endtask

  task automatic start_frame(input int a, input int b, input bit with_step);
    sample_x0  = 8'(a);
    sample_x1  = 8'(b);
    clk_en     = 1'b1;
    clk_en_10x = with_step;
    @(posedge clk); #1;
    clk_en     = 1'b0;
    clk_en_10x = 1'b0;
    m_x0 = a; m_x1 = b; m_k = 0; m_busy = 1'b1;
    chk("start_end_stage", 32'(end_stage), 32'd0);
    chk_y("start_hold");
  endtask

  task automatic step();
    int exp_end;
    exp_end    = 0;
    clk_en_10x = 1'b1;
    sample_x0  = 8'($urandom);
    sample_x1  = 8'($urandom);
    @(posedge clk); #1;
    clk_en_10x = 1'b0;
    if (m_busy) begin
      m_k++;
      if (m_k == 9) begin
        for (int i = 0; i < 10; i++) exp_y[i] = interp(m_x0, m_x1, i);
        m_busy  = 1'b0;
        exp_end = 1;
      end
    end
    chk("step_end_stage", 32'(end_stage), 32'(exp_end));
    chk_y("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_end_stage", 32'(end_stage), 32'd0);
      chk_y("idle");
    end
  endtask

  task automatic full_frame(input int a, input int b);
    start_frame(a, b, 1'b0);
    for (int s = 0; s < 9; s++) begin
      step();
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b0; clk_en_10x = 1'b0;
    sample_x0 = '0; sample_x1 = '0;
    m_busy = 1'b0; m_k = 0; m_x0 = 0; m_x1 = 0;
    for (int i = 0; i < 10; i++) exp_y[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_end_stage", 32'(end_stage), 32'd0);
    chk_y("reset");
    rst = 1'b1;
    idle(2);

    // Steps while idle do nothing
    for (int s = 0; s < 10; s++) step();

    // Directed frames from the verification list
    full_frame(0, 100);
    for (int i = 0; i < 10; i++) chk("ramp_up_const", 32'(ys[i]), 32'(10 * i));
    full_frame(200, 100);
    for (int i = 0; i < 10; i++) chk("ramp_down_const", 32'(ys[i]), 32'(200 - 10 * i));
    full_frame(0, 7);
    full_frame(255, 255);
    full_frame(0, 0);
    full_frame(0, 100);

    // Abort after 4 steps, restart with 50/50
    start_frame(0, 100, 1'b0);
    for (int s = 0; s < 4; s++) step();
    idle(1);
    start_frame(50, 50, 1'b0);
    for (int s = 0; s < 9; s++) step();
    for (int i = 0; i < 10; i++) chk("abort_const", 32'(ys[i]), 32'd50);
    idle(2);

    // Simultaneous frame and step strobes: step must not count
    start_frame(30, 230, 1'b1);
    for (int s = 0; s < 9; s++) step();
    idle(1);

    // Random frames, some aborted partway
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        start_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
        for (int s = 0; s < int'($urandom_range(0, 8)); s++) step();
      end
      full_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      idle(int'($urandom_range(0, 3)));
    end

    // Asynchronous reset mid-frame
    full_frame(17, 243);
    start_frame(0, 100, 1'b0);
    for (int s = 0; s < 5; s++) step();
    #3 rst = 1'b0;
    #1;
    m_busy = 1'b0; m_k = 0;
    for (int i = 0; i < 10; i++) exp_y[i] = 0;
    chk("async_reset_end_stage", 32'(end_stage), 32'd0);
    chk_y("async_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    for (int s = 0; s < 12; s++) step();
    full_frame(99, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
